// File: rtl/irq_prio_ctrl.sv
//------------------------------------------------------------------------------
// Module      : irq_prio_ctrl
// Description : Fixed-priority interrupt controller. It latches the
//               lowest-indexed enabled pending source, requests the core,
//               waits for trap entry (ack), then waits for handler
//               completion (mret). On completion it strobes the serviced
//               source with a one-hot int_fin_o.
// Config      : IRQ_EDGE_DETECT_EN - adds per-source rising-edge capture,
//               selected by edge_sel_i. When it is undefined, every source
//               is level sensitive.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module irq_prio_ctrl #(
  parameter int N_SRC = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] int_req_i,
  input  logic [N_SRC-1:0] mie_i,
`ifdef IRQ_EDGE_DETECT_EN
  input  logic [N_SRC-1:0] edge_sel_i,
`endif
  input  logic             int_ack_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [N_SRC-1:0] int_fin_o,
  output logic [31:0]      mcause_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_id;
  logic [4:0]       w_id;
  logic             r_int;
  logic [N_SRC-1:0] w_pend;
  logic [N_SRC-1:0] w_eff;
  logic [N_SRC-1:0] w_onehot;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_edge_pend;
  logic [N_SRC-1:0] w_rise;

  // A rising edge is captured only for sources configured as edge sensitive.
  assign w_rise = int_req_i & ~r_prev & edge_sel_i;

  // Edge history and sticky pending bits. A new edge wins over a same-cycle completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prev      <= '0;
      r_edge_pend <= '0;
    end else begin
      r_prev      <= int_req_i;
      r_edge_pend <= w_rise | (r_edge_pend & ~int_fin_o);
    end
  end

  assign w_pend = (edge_sel_i & r_edge_pend) | (~edge_sel_i & int_req_i);
`else
  assign w_pend = int_req_i;
`endif

  assign w_eff = w_pend & mie_i;

  // Priority encoder: scanning downwards leaves the lowest set index, which has the highest priority.
  always_comb begin
    w_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_eff[i]) w_id = i[4:0];
    end
  end

  // One-hot decode of the latched source, used for the completion strobe.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_onehot[i] = (r_id == i[4:0]);
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic and the completion strobe. In REQ, ack has precedence over rst.
  always_comb begin
    w_state_nxt = r_state;
    int_fin_o   = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_eff) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (int_ack_i) w_state_nxt = S_SERVICE;
      end
      S_SERVICE: begin
        if (int_rst_i) begin
          int_fin_o   = w_onehot;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The source id is captured only on the IDLE->REQ transition, so a latched request is never withdrawn or preempted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id <= '0;
    end else if (r_state == S_IDLE && |w_eff) begin
      r_id <= w_id;
    end
  end

  // The core request is a flop that is high exactly while the FSM sits in REQ.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_int <= 1'b0;
    else         r_int <= (w_state_nxt == S_REQ);
  end

  assign int_o    = r_int;
  assign mcause_o = {1'b1, 26'b0, r_id};

endmodule

`default_nettype wire
